// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the hardwired control sequencer of the single-bus
// 32-bit datapath: instruction opcodes, ALU operation codes, sequencer state
// and step encodings, instruction classes and the control-word struct that
// carries every datapath strobe.
// Used by: cu_decode, control_unit.
// Optional feature macro referenced by the users of this package:
//   CU_BRANCH_EN - enables the conditional branch (br) sequence.
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int OPC_W  = 5;
    localparam int ALU_W  = 6;
    localparam int STEP_W = 4;

    // Instruction opcodes, ir[31:27]
    localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'b01000;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'b01010;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b01011;
    localparam logic [OPC_W-1:0] OP_ANDI = 5'b01100;
    localparam logic [OPC_W-1:0] OP_ORI  = 5'b01101;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'b01110;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OPC_W-1:0] OP_NEG  = 5'b10000;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'b10001;
    localparam logic [OPC_W-1:0] OP_BR   = 5'b10010;
    localparam logic [OPC_W-1:0] OP_JR   = 5'b10011;
    localparam logic [OPC_W-1:0] OP_IN   = 5'b10110;
    localparam logic [OPC_W-1:0] OP_OUT  = 5'b10111;
    localparam logic [OPC_W-1:0] OP_MFHI = 5'b11000;
    localparam logic [OPC_W-1:0] OP_MFLO = 5'b11001;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

    // ALU operation codes: the ALU uses the zero-extended instruction opcode
    localparam logic [ALU_W-1:0] ALU_NONE = 6'b000000;
    localparam logic [ALU_W-1:0] ALU_ADD  = 6'b000011;
    localparam logic [ALU_W-1:0] ALU_SUB  = 6'b000100;
    localparam logic [ALU_W-1:0] ALU_AND  = 6'b000101;
    localparam logic [ALU_W-1:0] ALU_OR   = 6'b000110;
    localparam logic [ALU_W-1:0] ALU_MUL  = 6'b001110;
    localparam logic [ALU_W-1:0] ALU_DIV  = 6'b001111;
    localparam logic [ALU_W-1:0] ALU_NEG  = 6'b010000;
    localparam logic [ALU_W-1:0] ALU_NOT  = 6'b010001;

    // Execute step numbers
    localparam logic [STEP_W-1:0] T0 = 4'd0;
    localparam logic [STEP_W-1:0] T3 = 4'd3;
    localparam logic [STEP_W-1:0] T4 = 4'd4;
    localparam logic [STEP_W-1:0] T5 = 4'd5;
    localparam logic [STEP_W-1:0] T6 = 4'd6;
    localparam logic [STEP_W-1:0] T7 = 4'd7;
    localparam logic [STEP_W-1:0] T8 = 4'd8;

    typedef enum logic [2:0] {
        FETCH0 = 3'd0,
        FETCH1 = 3'd1,
        FETCH2 = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        CLS_ALU_RR, CLS_ALU_IMM, CLS_MULDIV, CLS_UNARY,
        CLS_LD, CLS_LDI, CLS_ST, CLS_BR, CLS_JR, CLS_IN, CLS_OUT,
        CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT
    } cls_t;

    typedef struct packed {
        logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in, y_in;
        logic zhigh_in, zlow_in, zhigh_out, zlow_out, hi_in, lo_in, hi_out, lo_out;
        logic c_out, inport_out, outport_in, con_in;
        logic read, write;
        logic gra, grb, grc, r_in, r_out, ba_out;
        logic [ALU_W-1:0] alu_op;
    } ctl_t;

    function automatic logic [ALU_W-1:0] alu_of(input logic [OPC_W-1:0] opc);
        return {1'b0, opc};
    endfunction

endpackage

// File: rtl/cu_decode.sv
// ---------------------------------------------------------------------------
// cu_decode
// Combinational instruction decoder: maps the opcode field to an instruction
// class and the last execute step of that class.
// Ports:
//   opcode     in   5  ir[31:27]
//   cls        out     instruction class
//   last_step  out  4  final execute step (T3..T8)
// Macro: CU_BRANCH_EN - br decodes to CLS_BR; otherwise br decodes as nop.
// ---------------------------------------------------------------------------
module cu_decode
    import cpu_pkg::*;
(
    input  logic [OPC_W-1:0]  opcode,
    output cls_t              cls,
    output logic [STEP_W-1:0] last_step
);

    // Trailing steps beyond the last active one are idle, so each class has a
    // fixed cycle count independent of how many steps drive the bus.
    always_comb begin
        cls       = CLS_NOP;
        last_step = T3;
        case (opcode)
            OP_LD:   begin cls = CLS_LD;  last_step = T8; end
            OP_LDI:  begin cls = CLS_LDI; last_step = T7; end
            OP_ST:   begin cls = CLS_ST;  last_step = T8; end
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL:
                     begin cls = CLS_ALU_RR;  last_step = T5; end
            OP_ADDI, OP_ANDI, OP_ORI:
                     begin cls = CLS_ALU_IMM; last_step = T5; end
            OP_MUL, OP_DIV:
                     begin cls = CLS_MULDIV;  last_step = T6; end
            OP_NEG, OP_NOT:
                     begin cls = CLS_UNARY;   last_step = T5; end
            OP_BR: begin
`ifdef CU_BRANCH_EN
                cls       = CLS_BR;
                last_step = T6;
`else
                cls       = CLS_NOP;
                last_step = T3;
`endif
            end
            OP_JR:   begin cls = CLS_JR;   last_step = T4; end
            OP_IN:   begin cls = CLS_IN;   last_step = T4; end
            OP_OUT:  begin cls = CLS_OUT;  last_step = T4; end
            OP_MFHI: begin cls = CLS_MFHI; last_step = T4; end
            OP_MFLO: begin cls = CLS_MFLO; last_step = T4; end
            OP_HALT: begin cls = CLS_HALT; last_step = T3; end
            default: begin cls = CLS_NOP;  last_step = T3; end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Hardwired multi-cycle control sequencer for the single-bus 32-bit datapath.
// Drives register enables, bus-source strobes, memory strobes and the ALU
// opcode each cycle from the state, the step counter and ir[31:27].
// Ports:
//   clk, clr (sync active-high reset), stop (halt request at instruction end)
//   ir[31:0], con (branch condition), mem_ready (memory completion)
//   run (low in HALT), datapath strobes, read/write, register-field selects,
//   alu_op[OPW-1:0]
// Macro: CU_BRANCH_EN - enables the conditional branch sequence for br.
//
// state  | meaning
// FETCH0 | PC to MAR, Z <= PC + 1
// FETCH1 | PC <= Z, memory read into MDR; waits for mem_ready
// FETCH2 | MDR to IR
// EXEC   | execute steps T3..T8 of the decoded class
// HALT   | all strobes off, run low; left only through clr
// ---------------------------------------------------------------------------
module control_unit
    import cpu_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           stop,
    input  logic [31:0]    ir,
    input  logic           con,
    input  logic           mem_ready,
    output logic           run,
    output logic           pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in, y_in,
    output logic           zhigh_in, zlow_in, zhigh_out, zlow_out, hi_in, lo_in, hi_out, lo_out,
    output logic           c_out, inport_out, outport_in, con_in,
    output logic           read, write,
    output logic           gra, grb, grc, r_in, r_out, ba_out,
    output logic [OPW-1:0] alu_op
);

    state_t            state, state_nxt;
    logic [STEP_W-1:0] step, step_nxt;
    cls_t              cls;
    logic [STEP_W-1:0] last_step;
    logic [OPC_W-1:0]  opc;
    logic              mem_wait;
    ctl_t              ctl;

    assign opc = ir[31:27];

`ifdef CU_BRANCH_EN
    logic unused_ir;
    assign unused_ir = ^ir[26:0];
`else
    logic unused_ir;
    assign unused_ir = ^{ir[26:0], con};
`endif

    cu_decode u_decode (
        .opcode    (opc),
        .cls       (cls),
        .last_step (last_step)
    );

    // Execute-phase memory waits: ld read at T6, st write at T7.
    assign mem_wait = (state == EXEC) && !mem_ready &&
                      (((cls == CLS_LD) && (step == T6)) ||
                       ((cls == CLS_ST) && (step == T7)));

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= FETCH0;
            step  <= T0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        case (state)
            FETCH0: state_nxt = FETCH1;
            FETCH1: if (mem_ready) state_nxt = FETCH2;
            FETCH2: begin
                state_nxt = EXEC;
                step_nxt  = T3;
            end
            EXEC: begin
                if (!mem_wait) begin
                    if (step >= last_step) begin
                        state_nxt = (stop || (cls == CLS_HALT)) ? HALT : FETCH0;
                        step_nxt  = T0;
                    end else begin
                        step_nxt = step + STEP_W'(1);
                    end
                end
            end
            HALT:    state_nxt = HALT;
            default: begin
                state_nxt = FETCH0;
                step_nxt  = T0;
            end
        endcase
    end

    always_comb begin
        ctl = '0;
        run = !((state == HALT) || ((state == EXEC) && (cls == CLS_HALT)));
        case (state)
            FETCH0: begin
                ctl.pc_out  = 1'b1;
                ctl.mar_in  = 1'b1;
                ctl.inc_pc  = 1'b1;
                ctl.zlow_in = 1'b1;
                ctl.alu_op  = ALU_ADD;
            end
            FETCH1: begin
                ctl.zlow_out = 1'b1;
                ctl.pc_in    = 1'b1;
                ctl.read     = 1'b1;
                ctl.mdr_in   = 1'b1;
            end
            FETCH2: begin
                ctl.mdr_out = 1'b1;
                ctl.ir_in   = 1'b1;
            end
            EXEC: begin
                case (cls)
                    CLS_ALU_RR, CLS_ALU_IMM, CLS_MULDIV: begin
                        case (step)
                            T3: begin
                                ctl.grb   = 1'b1;
                                ctl.r_out = 1'b1;
                                ctl.y_in  = 1'b1;
                            end
                            T4: begin
                                if (cls == CLS_ALU_IMM) begin
                                    ctl.c_out = 1'b1;
                                end else begin
                                    ctl.grc   = 1'b1;
                                    ctl.r_out = 1'b1;
                                end
                                ctl.zlow_in  = 1'b1;
                                ctl.zhigh_in = 1'b1;
                                ctl.alu_op   = alu_of(opc);
                            end
                            T5: begin
                                ctl.zlow_out = 1'b1;
                                if (cls == CLS_MULDIV) begin
                                    ctl.lo_in = 1'b1;
                                end else begin
                                    ctl.gra  = 1'b1;
                                    ctl.r_in = 1'b1;
                                end
                            end
                            T6: begin
                                if (cls == CLS_MULDIV) begin
                                    ctl.zhigh_out = 1'b1;
                                    ctl.hi_in     = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    CLS_UNARY: begin
                        case (step)
                            T3: begin
                                ctl.grb     = 1'b1;
                                ctl.r_out   = 1'b1;
                                ctl.zlow_in = 1'b1;
                                ctl.alu_op  = alu_of(opc);
                            end
                            T4: begin
                                ctl.zlow_out = 1'b1;
                                ctl.gra      = 1'b1;
                                ctl.r_in     = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        case (step)
                            T3: begin
                                ctl.grb    = 1'b1;
                                ctl.ba_out = 1'b1;
                                ctl.y_in   = 1'b1;
                            end
                            T4: begin
                                ctl.c_out   = 1'b1;
                                ctl.zlow_in = 1'b1;
                                ctl.alu_op  = ALU_ADD;
                            end
                            T5: begin
                                ctl.zlow_out = 1'b1;
                                if (cls == CLS_LDI) begin
                                    ctl.gra  = 1'b1;
                                    ctl.r_in = 1'b1;
                                end else begin
                                    ctl.mar_in = 1'b1;
                                end
                            end
                            T6: begin
                                if (cls == CLS_LD) begin
                                    ctl.read   = 1'b1;
                                    ctl.mdr_in = 1'b1;
                                end else if (cls == CLS_ST) begin
                                    ctl.gra    = 1'b1;
                                    ctl.r_out  = 1'b1;
                                    ctl.mdr_in = 1'b1;
                                end
                            end
                            T7: begin
                                if (cls == CLS_LD) begin
                                    ctl.mdr_out = 1'b1;
                                    ctl.gra     = 1'b1;
                                    ctl.r_in    = 1'b1;
                                end else if (cls == CLS_ST) begin
                                    ctl.write = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
`ifdef CU_BRANCH_EN
                    CLS_BR: begin
                        case (step)
                            T3: begin
                                ctl.gra    = 1'b1;
                                ctl.r_out  = 1'b1;
                                ctl.con_in = 1'b1;
                            end
                            T4: begin
                                ctl.pc_out = 1'b1;
                                ctl.y_in   = 1'b1;
                            end
                            T5: begin
                                ctl.c_out   = 1'b1;
                                ctl.zlow_in = 1'b1;
                                ctl.alu_op  = ALU_ADD;
                            end
                            T6: begin
                                // Branch not taken leaves T6 as an idle cycle
                                ctl.zlow_out = con;
                                ctl.pc_in    = con;
                            end
                            default: ;
                        endcase
                    end
`endif
                    CLS_JR: begin
                        if (step == T3) begin
                            ctl.gra   = 1'b1;
                            ctl.r_out = 1'b1;
                            ctl.pc_in = 1'b1;
                        end
                    end
                    CLS_IN: begin
                        if (step == T3) begin
                            ctl.inport_out = 1'b1;
                            ctl.gra        = 1'b1;
                            ctl.r_in       = 1'b1;
                        end
                    end
                    CLS_OUT: begin
                        if (step == T3) begin
                            ctl.gra        = 1'b1;
                            ctl.r_out      = 1'b1;
                            ctl.outport_in = 1'b1;
                        end
                    end
                    CLS_MFHI: begin
                        if (step == T3) begin
                            ctl.hi_out = 1'b1;
                            ctl.gra    = 1'b1;
                            ctl.r_in   = 1'b1;
                        end
                    end
                    CLS_MFLO: begin
                        if (step == T3) begin
                            ctl.lo_out = 1'b1;
                            ctl.gra    = 1'b1;
                            ctl.r_in   = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
        // Strobes are forced off in the reset cycle whatever state was held
        if (clr) ctl = '0;
    end

    assign pc_out     = ctl.pc_out;
    assign pc_in      = ctl.pc_in;
    assign inc_pc     = ctl.inc_pc;
    assign mar_in     = ctl.mar_in;
    assign mdr_in     = ctl.mdr_in;
    assign mdr_out    = ctl.mdr_out;
    assign ir_in      = ctl.ir_in;
    assign y_in       = ctl.y_in;
    assign zhigh_in   = ctl.zhigh_in;
    assign zlow_in    = ctl.zlow_in;
    assign zhigh_out  = ctl.zhigh_out;
    assign zlow_out   = ctl.zlow_out;
    assign hi_in      = ctl.hi_in;
    assign lo_in      = ctl.lo_in;
    assign hi_out     = ctl.hi_out;
    assign lo_out     = ctl.lo_out;
    assign c_out      = ctl.c_out;
    assign inport_out = ctl.inport_out;
    assign outport_in = ctl.outport_in;
    assign con_in     = ctl.con_in;
    assign read       = ctl.read;
    assign write      = ctl.write;
    assign gra        = ctl.gra;
    assign grb        = ctl.grb;
    assign grc        = ctl.grc;
    assign r_in       = ctl.r_in;
    assign r_out      = ctl.r_out;
    assign ba_out     = ctl.ba_out;
    assign alu_op     = OPW'(ctl.alu_op);

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
// Scoreboard bench for control_unit: each scenario queues per-cycle stimulus
// together with the expected strobe word; the drain loop applies the stimulus
// one cycle at a time and compares the observed strobe word against it.
// ---------------------------------------------------------------------------
module tb_control_unit;

    localparam int OPW = 6;

    logic clk = 1'b0;
    logic clr, stop, con, mem_ready;
    logic [31:0] ir;
    logic run;
    logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in, y_in;
    logic zhigh_in, zlow_in, zhigh_out, zlow_out, hi_in, lo_in, hi_out, lo_out;
    logic c_out, inport_out, outport_in, con_in;
    logic read, write;
    logic gra, grb, grc, r_in, r_out, ba_out;
    logic [OPW-1:0] alu_op;

    control_unit #(.OPW(OPW)) dut (
        .clk(clk), .clr(clr), .stop(stop), .ir(ir), .con(con), .mem_ready(mem_ready),
        .run(run),
        .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in),
        .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in),
        .zhigh_in(zhigh_in), .zlow_in(zlow_in), .zhigh_out(zhigh_out), .zlow_out(zlow_out),
        .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_out), .lo_out(lo_out),
        .c_out(c_out), .inport_out(inport_out), .outport_in(outport_in), .con_in(con_in),
        .read(read), .write(write),
        .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
        .alu_op(alu_op)
    );

    always #5 clk = ~clk;

    // Observed strobe word: bit 0..27 strobes, bit 28 run, bits 34:29 alu_op
    logic [39:0] obs;
    assign obs = {5'd0, alu_op, run, ba_out, r_out, r_in, grc, grb, gra, write, read,
                  con_in, outport_in, inport_out, c_out, lo_out, hi_out, lo_in, hi_in,
                  zlow_out, zhigh_out, zlow_in, zhigh_in, y_in, ir_in, mdr_out, mdr_in,
                  mar_in, inc_pc, pc_in, pc_out};

    localparam logic [39:0] B1         = 40'h1;
    localparam logic [39:0] PC_OUT     = B1 << 0;
    localparam logic [39:0] PC_IN      = B1 << 1;
    localparam logic [39:0] INC_PC     = B1 << 2;
    localparam logic [39:0] MAR_IN     = B1 << 3;
    localparam logic [39:0] MDR_IN     = B1 << 4;
    localparam logic [39:0] MDR_OUT    = B1 << 5;
    localparam logic [39:0] IR_IN      = B1 << 6;
    localparam logic [39:0] Y_IN       = B1 << 7;
    localparam logic [39:0] ZHIGH_IN   = B1 << 8;
    localparam logic [39:0] ZLOW_IN    = B1 << 9;
    localparam logic [39:0] ZHIGH_OUT  = B1 << 10;
    localparam logic [39:0] ZLOW_OUT   = B1 << 11;
    localparam logic [39:0] HI_IN      = B1 << 12;
    localparam logic [39:0] LO_IN      = B1 << 13;
    localparam logic [39:0] HI_OUT     = B1 << 14;
    localparam logic [39:0] LO_OUT     = B1 << 15;
    localparam logic [39:0] C_OUT      = B1 << 16;
    localparam logic [39:0] INPORT_OUT = B1 << 17;
    localparam logic [39:0] OUTPORT_IN = B1 << 18;
    localparam logic [39:0] CON_IN     = B1 << 19;
    localparam logic [39:0] READ       = B1 << 20;
    localparam logic [39:0] WRITE      = B1 << 21;
    localparam logic [39:0] GRA        = B1 << 22;
    localparam logic [39:0] GRB        = B1 << 23;
    localparam logic [39:0] GRC        = B1 << 24;
    localparam logic [39:0] R_IN       = B1 << 25;
    localparam logic [39:0] R_OUT      = B1 << 26;
    localparam logic [39:0] BA_OUT     = B1 << 27;
    localparam logic [39:0] RUN        = B1 << 28;
    localparam logic [39:0] ALL        = {40{1'b1}};

    function automatic logic [39:0] op(input int v);
        return 40'(v) << 29;
    endfunction

    localparam logic [39:0] F0 = RUN | PC_OUT | MAR_IN | INC_PC | ZLOW_IN | (40'd3 << 29);
    localparam logic [39:0] F1 = RUN | ZLOW_OUT | PC_IN | READ | MDR_IN;
    localparam logic [39:0] F2 = RUN | MDR_OUT | IR_IN;

    typedef struct packed {
        logic        clr;
        logic        stop;
        logic        mr;
        logic        con;
        logic [31:0] ir;
        logic [39:0] want;
        logic [39:0] mask;
    } ent_t;

    ent_t sb[$];
    logic        cur_stop, cur_mr, cur_con;
    logic [31:0] cur_ir;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] opcode);
        logic [31:0] v;
        v = {opcode, 27'h2A5_3C1};
        return v;
    endfunction

    task automatic push(input logic [39:0] e);
        sb.push_back('{clr: 1'b0, stop: cur_stop, mr: cur_mr, con: cur_con,
                       ir: cur_ir, want: e, mask: ALL});
    endtask

    // Reset cycle: every strobe and alu_op must be low, run is not compared
    task automatic push_clr();
        sb.push_back('{clr: 1'b1, stop: cur_stop, mr: cur_mr, con: cur_con,
                       ir: cur_ir, want: 40'd0, mask: ~RUN});
    endtask

    task automatic push_fetch();
        push(F0);
        push(F1);
        push(F2);
    endtask

    task automatic drain(input string tag);
        ent_t e;
        int n;
        n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            clr       = e.clr;
            stop      = e.stop;
            mem_ready = e.mr;
            con       = e.con;
            ir        = e.ir;
            #2;
            check($sformatf("%s[%0d]", tag, n), obs & e.mask, e.want);
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clr = 1'b1; stop = 1'b0; con = 1'b0; mem_ready = 1'b1; ir = 32'd0;
        cur_stop = 1'b0; cur_mr = 1'b1; cur_con = 1'b0;

        // reset then add: 6 cycles, back at FETCH0 on the next one
        cur_ir = mk_ir(5'b00011);
        push_clr();
        push_fetch();
        push(RUN | GRB | R_OUT | Y_IN);
        push(RUN | GRC | R_OUT | ZLOW_IN | ZHIGH_IN | op(3));
        push(RUN | ZLOW_OUT | GRA | R_IN);
        drain("add");

        // addi: immediate via c_out at T4
        cur_ir = mk_ir(5'b01011);
        push_fetch();
        push(RUN | GRB | R_OUT | Y_IN);
        push(RUN | C_OUT | ZLOW_IN | ZHIGH_IN | op(11));
        push(RUN | ZLOW_OUT | GRA | R_IN);
        drain("addi");

        // neg: two active steps plus an idle T5
        cur_ir = mk_ir(5'b10000);
        push_fetch();
        push(RUN | GRB | R_OUT | ZLOW_IN | op(16));
        push(RUN | ZLOW_OUT | GRA | R_IN);
        push(RUN);
        drain("neg");

        // ld with mem_ready low for 3 cycles at T6: 12 cycles total
        cur_ir = mk_ir(5'b00000);
        push_fetch();
        push(RUN | GRB | BA_OUT | Y_IN);
        push(RUN | C_OUT | ZLOW_IN | op(3));
        push(RUN | ZLOW_OUT | MAR_IN);
        cur_mr = 1'b0;
        push(RUN | READ | MDR_IN);
        push(RUN | READ | MDR_IN);
        push(RUN | READ | MDR_IN);
        cur_mr = 1'b1;
        push(RUN | READ | MDR_IN);
        push(RUN | MDR_OUT | GRA | R_IN);
        push(RUN);
        drain("ld");

        // st with a 2-cycle fetch wait and a 1-cycle write wait
        cur_ir = mk_ir(5'b00010);
        push(F0);
        cur_mr = 1'b0;
        push(F1);
        push(F1);
        cur_mr = 1'b1;
        push(F1);
        push(F2);
        push(RUN | GRB | BA_OUT | Y_IN);
        push(RUN | C_OUT | ZLOW_IN | op(3));
        push(RUN | ZLOW_OUT | MAR_IN);
        push(RUN | GRA | R_OUT | MDR_IN);
        cur_mr = 1'b0;
        push(RUN | WRITE);
        cur_mr = 1'b1;
        push(RUN | WRITE);
        push(RUN);
        drain("st");

        // jr with a stop pulse that is low at the final edge: ignored
        cur_ir = mk_ir(5'b10011);
        push_fetch();
        cur_stop = 1'b1;
        push(RUN | GRA | R_OUT | PC_IN);
        cur_stop = 1'b0;
        push(RUN);
        drain("jr");

        cur_ir = mk_ir(5'b11000);
        push_fetch();
        push(RUN | HI_OUT | GRA | R_IN);
        push(RUN);
        drain("mfhi");

        cur_ir = mk_ir(5'b10110);
        push_fetch();
        push(RUN | INPORT_OUT | GRA | R_IN);
        push(RUN);
        drain("in");

        // unused opcode behaves as nop: 4 cycles, no execute strobes
        cur_ir = mk_ir(5'b11111);
        push_fetch();
        push(RUN);
        drain("op1f");

        // br taken, then not taken
        cur_ir = mk_ir(5'b10010);
        cur_con = 1'b1;
        push_fetch();
`ifdef CU_BRANCH_EN
        push(RUN | GRA | R_OUT | CON_IN);
        push(RUN | PC_OUT | Y_IN);
        push(RUN | C_OUT | ZLOW_IN | op(3));
        push(RUN | ZLOW_OUT | PC_IN);
`else
        push(RUN);
`endif
        drain("br_t");
        cur_con = 1'b0;
        push_fetch();
`ifdef CU_BRANCH_EN
        push(RUN | GRA | R_OUT | CON_IN);
        push(RUN | PC_OUT | Y_IN);
        push(RUN | C_OUT | ZLOW_IN | op(3));
        push(RUN);
`else
        push(RUN);
`endif
        drain("br_nt");

        // clr during the FETCH1 wait restarts at FETCH0 without an ir_in pulse
        cur_ir = mk_ir(5'b11010);
        push(F0);
        cur_mr = 1'b0;
        push(F1);
        push(F1);
        push_clr();
        cur_mr = 1'b1;
        push_fetch();
        push(RUN);
        drain("clr_wait");

        // mul with stop raised mid-instruction: HI written at T6, then HALT
        cur_ir = mk_ir(5'b01110);
        push_fetch();
        push(RUN | GRB | R_OUT | Y_IN);
        cur_stop = 1'b1;
        push(RUN | GRC | R_OUT | ZLOW_IN | ZHIGH_IN | op(14));
        push(RUN | ZLOW_OUT | LO_IN);
        push(RUN | ZHIGH_OUT | HI_IN);
        cur_stop = 1'b0;
        for (int i = 0; i < 20; i++) push(40'd0);
        push_clr();
        drain("mul_stop");

        // halt opcode: run drops in the cycle after FETCH2; clr+stop together
        cur_ir = mk_ir(5'b11011);
        push_fetch();
        push(40'd0);
        push(40'd0);
        push(40'd0);
        cur_stop = 1'b1;
        push_clr();
        cur_ir = mk_ir(5'b11010);
        push_fetch();
        cur_stop = 1'b0;
        push(RUN);
        push(F0);
        drain("halt");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
